// File: rtl/mem_port_arbiter.sv
// Shares one request/ack memory port between fetch and data access, data first, stalling the pipeline until both are served.
// Optional ack watchdog under `MEM_ARB_TIMEOUT_EN`; without it the port waits for ack indefinitely.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t state, state_nxt;
    logic   dm_done, if_done, orphan;
    logic   dm_req, dm_pend, if_pend, advance, ack, tmo;
    logic   issue_dm, issue_if, fin_dm, fin_if;

    assign dm_req    = dm_read_i | dm_write_i;
    assign dm_pend   = dm_req & ~dm_done;
    assign if_pend   = if_req_i & ~if_done;
    assign stall_o   = dm_pend | if_pend;
    assign advance   = ~stall_o;
    assign mem_req_o = (state == DATA) || (state == FETCH);
    assign ack       = mem_ack_i | tmo;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // An orphaned access (its request went away) still runs to its ack, but its result is dropped.
    always_comb begin
        state_nxt = state;
        issue_dm  = 1'b0;
        issue_if  = 1'b0;
        fin_dm    = 1'b0;
        fin_if    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_pend) begin
                    state_nxt = DATA;
                    issue_dm  = 1'b1;
                end else if (if_pend) begin
                    state_nxt = FETCH;
                    issue_if  = 1'b1;
                end
            end
            DATA: begin
                if (ack) begin
                    fin_dm = dm_req & ~orphan;
                    if (if_pend) begin
                        state_nxt = FETCH;
                        issue_if  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FETCH: begin
                if (ack) begin
                    fin_if    = if_req_i & ~orphan;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
            dm_done     <= 1'b0;
            if_done     <= 1'b0;
            orphan      <= 1'b0;
        end else begin
            if (issue_dm) begin
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
                mem_we_o    <= dm_write_i;
            end else if (issue_if) begin
                mem_addr_o <= if_addr_i;
                mem_we_o   <= 1'b0;
            end

            if (fin_dm && !mem_we_o) dm_rdata_o <= tmo ? '0 : mem_rdata_i;
            if (fin_if)              if_data_o  <= tmo ? '0 : mem_rdata_i;

            if (advance) begin
                dm_done <= 1'b0;
                if_done <= 1'b0;
            end else begin
                if (fin_dm) dm_done <= 1'b1;
                if (fin_if) if_done <= 1'b1;
            end

            if (mem_req_o && ack)          orphan <= 1'b0;
            else if (mem_req_o && advance) orphan <= 1'b1;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign tmo   = mem_req_o && !mem_ack_i && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (issue_dm || issue_if)        wait_cnt <= '0;
            else if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + CNT_W'(1);
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a wait-state memory responder plus hand-computed expectations.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        dm_read_i = 1'b0;
    logic        dm_write_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    // Responder controls
    bit resp_en   = 1'b1;
    bit force_ack = 1'b0;
    int ws        = 0;
    int wcnt      = 0;
    bit req_last  = 1'b0;
    bit ack_last  = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
        .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8C22_0004;
            32'h44:  return 32'h0022_1820;
            32'h100: return 32'h1234_5678;
            default: return 32'hA5A5_0000 | a;
        endcase
    endfunction

    // Acks each access after ws wait states; mem_rdata_i is junk except on the ack cycle.
    always @(posedge clk) begin
        #1;
        if (resp_en && mem_req_o) begin
            wcnt        = (!req_last || ack_last) ? 0 : wcnt + 1;
            mem_ack_i   = (wcnt == ws);
            mem_rdata_i = mem_ack_i ? mem_word(mem_addr_o) : 32'hBAD0_0000;
        end else begin
            mem_ack_i   = force_ack;
            mem_rdata_i = force_ack ? 32'hFFFF_FFFF : 32'hBAD0_0000;
        end
        req_last = mem_req_o;
        ack_last = mem_ack_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after inputs are driven at a negedge; counts stalled cycles, bounded.
    task automatic run_access(input string tag, input int exp_stall,
                              output logic [31:0] first_addr, output logic [31:0] last_addr,
                              output logic first_we);
        int  n = 0;
        bit  seen = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        first_we   = 1'b0;
        #1;
        while (stall_o && n < 60) begin
            if (mem_req_o) begin
                if (!seen) begin
                    first_addr = mem_addr_o;
                    first_we   = mem_we_o;
                    seen       = 1'b1;
                end
                last_addr = mem_addr_o;
            end
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall_cycles"}, n, exp_stall);
    endtask

    task automatic clear_inputs();
        if_req_i   = 1'b0;
        dm_read_i  = 1'b0;
        dm_write_i = 1'b0;
    endtask

    logic [31:0] fa, la;
    logic        fwe;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_if_data", if_data_o, 0);
        check("rst_dm_rdata", dm_rdata_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // Fetch only, zero wait
        @(negedge clk);
        ws = 0; if_req_i = 1'b1; if_addr_i = 32'h40;
        run_access("fetch0", 2, fa, la, fwe);
        check("fetch0_addr", fa, 32'h40);
        check("fetch0_we", fwe, 0);
        check("fetch0_data", if_data_o, 32'h8C22_0004);
        clear_inputs();

        // Load + fetch, 2 wait states each
        @(negedge clk);
        ws = 2; dm_read_i = 1'b1; dm_addr_i = 32'h100; if_req_i = 1'b1; if_addr_i = 32'h44;
        run_access("ldf", 7, fa, la, fwe);
        check("ldf_first_addr", fa, 32'h100);
        check("ldf_last_addr", la, 32'h44);
        check("ldf_first_we", fwe, 0);
        check("ldf_dm_rdata", dm_rdata_o, 32'h1234_5678);
        check("ldf_if_data", if_data_o, 32'h0022_1820);
        clear_inputs();

        // Store with read also asserted, 1 wait state
        @(negedge clk);
        ws = 1; dm_write_i = 1'b1; dm_read_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD_BEEF;
        run_access("st", 3, fa, la, fwe);
        check("st_addr", fa, 32'h200);
        check("st_we", fwe, 1);
        check("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("st_dm_rdata_kept", dm_rdata_o, 32'h1234_5678);
        clear_inputs();

        // Ack pulses while idle
        @(negedge clk);
        resp_en = 1'b0; force_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_ack_req", mem_req_o, 0);
        check("idle_ack_stall", stall_o, 0);
        check("idle_ack_dm_rdata", dm_rdata_o, 32'h1234_5678);
        check("idle_ack_if_data", if_data_o, 32'h0022_1820);
        force_ack = 1'b0; resp_en = 1'b1;
        @(negedge clk);
        ws = 0; if_req_i = 1'b1; if_addr_i = 32'h4C;
        run_access("post_idle_fetch", 2, fa, la, fwe);
        check("post_idle_fetch_data", if_data_o, 32'hA5A5_004C);
        clear_inputs();

        // Reset in the middle of a data wait
        @(negedge clk);
        ws = 5; dm_read_i = 1'b1; dm_addr_i = 32'h300; if_req_i = 1'b1; if_addr_i = 32'h50;
        repeat (2) @(negedge clk);
        #1;
        check("mid_data_req", mem_req_o, 1);
        rst_i = 1'b1;
        clear_inputs();
        @(negedge clk);
        #1;
        check("midrst_mem_req", mem_req_o, 0);
        check("midrst_stall", stall_o, 0);
        check("midrst_if_data", if_data_o, 0);
        check("midrst_dm_rdata", dm_rdata_o, 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        check("midrst_mem_wdata", mem_wdata_o, 0);
        check("midrst_mem_we", mem_we_o, 0);
        rst_i = 1'b0;
        resp_en = 1'b0; force_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("late_ack_req", mem_req_o, 0);
        check("late_ack_dm_rdata", dm_rdata_o, 0);
        check("late_ack_if_data", if_data_o, 0);
        force_ack = 1'b0; resp_en = 1'b1;

        // Fetch with 1 wait state after reset
        @(negedge clk);
        ws = 1; if_req_i = 1'b1; if_addr_i = 32'h48;
        run_access("fetch1", 3, fa, la, fwe);
        check("fetch1_data", if_data_o, 32'hA5A5_0048);
        check("fetch1_err", err_o, 0);
        clear_inputs();

`ifdef MEM_ARB_TIMEOUT_EN
        // Never-acked fetch aborts after 4 wait cycles
        @(negedge clk);
        resp_en = 1'b0; force_ack = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h80;
        run_access("tmo", 6, fa, la, fwe);
        check("tmo_addr", fa, 32'h80);
        check("tmo_if_data", if_data_o, 0);
        check("tmo_err", err_o, 1);
        clear_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("tmo_err_sticky", err_o, 1);
        check("tmo_stall_after", stall_o, 0);
        resp_en = 1'b1;
`else
        repeat (2) @(negedge clk);
        #1;
        check("err_tied_low", err_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the pipeline's single shared memory port between instruction fetch (IF stage) and data access (MEM stage), replacing separate instruction and data memories with one backing memory that uses a request/acknowledge handshake. The block serves at most one access at a time, data before fetch, and holds the whole pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) through `stall_o` until every request presented this cycle has completed. Read results are held in output registers so the pipeline consumes them on the cycle it advances.

## Interface
- `ADDR_W`, 32, address width of all address ports
- `DATA_W`, 32, data width of all data ports
- `TIMEOUT_CYCLES`, 255, ack watchdog limit; used only with `MEM_ARB_TIMEOUT_EN`

- `clk_i` in 1: clock, all logic on rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `if_req_i` in 1: fetch request from the IF stage
- `if_addr_i` in ADDR_W: fetch address (PC)
- `if_data_o` out DATA_W: fetched instruction, registered
- `dm_read_i` in 1: data read request from the MEM stage
- `dm_write_i` in 1: data write request from the MEM stage
- `dm_addr_i` in ADDR_W: data address
- `dm_wdata_i` in DATA_W: data to write
- `dm_rdata_o` out DATA_W: read data, registered
- `stall_o` out 1: freeze all pipeline registers and the PC
- `mem_req_o` out 1: backing memory request
- `mem_we_o` out 1: 1 = write, 0 = read
- `mem_addr_o` out ADDR_W: backing memory address, registered
- `mem_wdata_o` out DATA_W: backing memory write data, registered
- `mem_ack_i` in 1: access complete; `mem_rdata_i` is valid in the same cycle
- `mem_rdata_i` in DATA_W: backing memory read data
- `err_o` out 1: sticky timeout flag

## Operation
- **Derived signals**
  - `dm_req = dm_read_i | dm_write_i`.
  - Served flags `dm_done` and `if_done` are registered.
  - `stall_o = (dm_req & ~dm_done) | (if_req_i & ~if_done)`. This is combinational from the inputs and the flags.
- **Advance cycle:** a rising edge with `stall_o == 0` is an advance. Both done flags clear on it, so the next requests start unserved.
- **FSM states:** IDLE, DATA, FETCH. `mem_req_o = (state == DATA) | (state == FETCH)`.
- **IDLE**
  - Unserved data request: go to DATA. Latch `dm_addr_i` and `dm_wdata_i` into `mem_addr_o` and `mem_wdata_o`. Latch `mem_we_o = dm_write_i`.
  - Otherwise, unserved fetch: go to FETCH. Latch `if_addr_i` and set `mem_we_o = 0`.
  - Otherwise stay in IDLE.
- **DATA**
  - Hold all `mem_*` outputs stable until `mem_ack_i`.
  - On ack: on a read, capture `mem_rdata_i` into `dm_rdata_o`; on a write, leave `dm_rdata_o` unchanged. Set `dm_done`.
  - After the ack, go directly to FETCH (latching the fetch address) if a fetch is unserved; otherwise go to IDLE.
- **FETCH**
  - Hold the `mem_*` outputs stable until ack.
  - On ack: capture `mem_rdata_i` into `if_data_o`, set `if_done`, go to IDLE.
- **Boundary conditions**
  - `dm_read_i` and `dm_write_i` high together: the write wins and `mem_we_o = 1`.
  - `mem_ack_i` in IDLE is ignored.
  - Requests may change only on an advance. Input changes while stalled, other than deassertion, are ignored once the corresponding address is latched.
  - A request that drops while unserved simply stops being served. An access already issued on the port completes, and its result is discarded.
- **Reset** (any time, including mid-access)
  - Next state is IDLE and `mem_req_o` is 0 the following cycle.
  - Both flags are cleared, and `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `if_data_o`, `dm_rdata_o` and `err_o` are 0.
  - A late ack arriving after reset is ignored.

## Timing
- Request-to-`mem_req_o` latency: 1 cycle.
- With zero-wait memory (ack in the first request cycle):
  - fetch only: `stall_o` is high for 2 cycles;
  - data + fetch: `stall_o` is high for 3 cycles;
  - no requests: `stall_o` is 0.
- Each wait state adds exactly 1 stall cycle.
- Captured data is valid from the cycle after the ack until the advance edge.

## Configuration
- **With `MEM_ARB_TIMEOUT_EN` defined**
  - An 8-bit-or-wider wait counter resets on entry to DATA or FETCH and increments every cycle without an ack.
  - When the counter reaches `TIMEOUT_CYCLES`, the access aborts: the captured data is 0, the corresponding done flag is set, `err_o` is set, and the FSM proceeds as if acked.
  - `err_o` clears only on reset.
- **Without the macro:** the FSM waits indefinitely for the ack and `err_o` is tied to 0.

## Test plan
- **Reset:** assert `rst_i` during a DATA wait → next cycle `mem_req_o=0`, `stall_o=0` (with no inputs), all data outputs 0; then an ack arriving is ignored.
- **Fetch only, zero-wait:** `if_req_i=1`, `if_addr_i=0x40`, ack in the first cycle with rdata `0x8C220004` → `stall_o` high for 2 cycles, `if_data_o=0x8C220004`, `mem_we_o=0`.
- **Load + fetch:** `dm_read_i=1`, `dm_addr_i=0x100`, `if_addr_i=0x44`, each access with 2 wait states → the data access is issued first at 0x100 with 2 wait states, then FETCH at 0x44; `stall_o` high for 7 cycles; `dm_rdata_o` and `if_data_o` hold their respective words.
- **Store with read also high:** `dm_write_i=1`, `dm_read_i=1`, `dm_wdata_i=0xDEADBEEF` → `mem_we_o=1`, `mem_wdata_o=0xDEADBEEF`, `dm_rdata_o` unchanged.
- **Ack hygiene:** inject `mem_ack_i` pulses in IDLE → no flag changes and no state change.
- **With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`:** never ack a fetch → abort after 4 wait cycles, `if_data_o=0`, `err_o=1` stays high, pipeline advances.
